// File: rtl/sha256_uart_host_pkg.sv
// Shared constants, state encoding and ASCII-hex decode for the SHA-256 UART host.
// Used by the host controller and its interface users.
package sha256_uart_host_pkg;

   localparam logic [7:0] CMD_START = 8'h01;
   localparam logic [7:0] CMD_TERM  = 8'hFF;

   localparam logic [1:0] ERR_OK  = 2'd0;
   localparam logic [1:0] ERR_FF  = 2'd1;
   localparam logic [1:0] ERR_HEX = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   localparam int NIB_W = 6;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TX_CMD  = 3'd1,
      TX_DATA = 3'd2,
      TX_TERM = 3'd3,
      RX_HEX  = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Returns {valid, nibble}; valid is low for anything that is not a hex digit.
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
      else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
      else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
      return r;
   endfunction

endpackage

// File: rtl/sha256_uart_host_if.sv
// Host-side bus of the SHA-256 UART host: start pulse, valid/ready message stream, digest/status.
// master = the user driving messages, slave = the host block.
interface sha256_uart_host_if;
   logic         start;
   logic [7:0]   msg_data;
   logic         msg_valid;
   logic         msg_last;
   logic         msg_ready;
   logic [255:0] digest;
   logic         digest_valid;
   logic         busy;
   logic [1:0]   err;

   modport master (
      output start, msg_data, msg_valid, msg_last,
      input  msg_ready, digest, digest_valid, busy, err
   );

   modport slave (
      input  start, msg_data, msg_valid, msg_last,
      output msg_ready, digest, digest_valid, busy, err
   );
endinterface

// File: rtl/sha256_uart_host_uart.sv
// 8N1 UART transmit and receive cores, BAUD_DIV clocks per bit.
// TX: busy rises the cycle after i_start and falls after the stop bit; RX: 1-cycle o_valid at mid stop bit.
module uart_tx_core #(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_busy
);
   localparam int            CW   = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [9:0]    r_shift;
   logic [3:0]    r_bit;
   logic [CW-1:0] r_baud;
   logic          r_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '1;
         r_bit   <= '0;
         r_baud  <= '0;
         r_busy  <= 1'b0;
      end else if (!r_busy) begin
         if (i_start) begin
            r_shift <= {1'b1, i_data, 1'b0};
            r_bit   <= '0;
            r_baud  <= '0;
            r_busy  <= 1'b1;
         end
      end else if (r_baud == LAST) begin
         r_baud  <= '0;
         r_shift <= {1'b1, r_shift[9:1]};
         if (r_bit == 4'd9) r_busy <= 1'b0;
         else               r_bit  <= r_bit + 4'd1;
      end else begin
         r_baud <= r_baud + 1'b1;
      end
   end

   assign o_tx   = r_shift[0];
   assign o_busy = r_busy;
endmodule

module uart_rx_core #(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid
);
   localparam int            CW   = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] MID  = CW'((BAUD_DIV / 2 > 0) ? BAUD_DIV / 2 - 1 : 0);

   logic [1:0]    r_sync;
   logic          r_active;
   logic [3:0]    r_bit;
   logic [CW-1:0] r_baud;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          w_rx;
   logic          w_tick;

   assign w_rx   = r_sync[1];
   // Start bit waits half a bit so every later sample lands mid-bit.
   assign w_tick = (r_bit == 4'd0) ? (r_baud == MID) : (r_baud == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync   <= 2'b11;
         r_active <= 1'b0;
         r_bit    <= '0;
         r_baud   <= '0;
         r_shift  <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_rx};
         r_valid <= 1'b0;
         if (!r_active) begin
            if (!w_rx) begin
               r_active <= 1'b1;
               r_bit    <= '0;
               r_baud   <= '0;
            end
         end else if (w_tick) begin
            r_baud <= '0;
            if (r_bit == 4'd0) begin
               if (w_rx) r_active <= 1'b0;
               else      r_bit    <= 4'd1;
            end else if (r_bit <= 4'd8) begin
               r_shift <= {w_rx, r_shift[7:1]};
               r_bit   <= r_bit + 4'd1;
            end else begin
               r_active <= 1'b0;
               if (w_rx) begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
               end
            end
         end else begin
            r_baud <= r_baud + 1'b1;
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
endmodule

// File: rtl/sha256_uart_host.sv
// Streams a message to a UART SHA-256 device (01, data, FF) and decodes its 64-char hex reply into a digest.
// msg_ready only when the transmitter is idle with no send pending; one byte in flight at a time.
module sha256_uart_host
   import sha256_uart_host_pkg::*;
#(
   parameter int CLK_FREQ       = 100_000_000,
   parameter int BAUD           = 115200,
   parameter int TIMEOUT_CYCLES = 20_000_000
) (
   input  logic                clk,
   input  logic                rst,
   sha256_uart_host_if.slave   host,
   output logic                o_uart_tx,
   input  logic                i_uart_rx
);
   localparam int                BAUD_DIV = CLK_FREQ / BAUD;
   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_err, w_err_nxt;
   logic [255:0]       r_digest, w_digest_nxt;
   logic [NIB_W-1:0]   r_nib_cnt, w_nib_cnt_nxt;
   logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;

   logic               r_tx_start;
   logic [7:0]         r_tx_data;
   logic               r_tx_pend;
   logic               r_tx_seen;

   logic               w_issue;
   logic [7:0]         w_issue_dat;
   logic               w_send_ok;
   logic               w_msg_ready;
   logic               w_tx_busy;
   logic               w_rx_vld;
   logic [7:0]         w_rx_dat;
   logic [4:0]         w_dec;

   uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .i_start (r_tx_start),
      .i_data  (r_tx_data),
      .o_tx    (o_uart_tx),
      .o_busy  (w_tx_busy)
   );

   uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .i_rx    (i_uart_rx),
      .o_data  (w_rx_dat),
      .o_valid (w_rx_vld)
   );

   // r_tx_pend covers the gap between the start pulse and the core raising busy.
   assign w_send_ok = !r_tx_pend && !w_tx_busy;
   assign w_dec     = hex_decode(w_rx_dat);

   always_comb begin
      w_state_nxt   = r_state;
      w_err_nxt     = r_err;
      w_digest_nxt  = r_digest;
      w_nib_cnt_nxt = r_nib_cnt;
      w_tmo_cnt_nxt = r_tmo_cnt;
      w_issue       = 1'b0;
      w_issue_dat   = CMD_START;
      w_msg_ready   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (host.start) begin
               w_err_nxt     = ERR_OK;
               w_nib_cnt_nxt = '0;
               w_tmo_cnt_nxt = '0;
               w_state_nxt   = TX_CMD;
            end
         end
         TX_CMD: begin
            if (w_send_ok) begin
               w_issue     = 1'b1;
               w_issue_dat = CMD_START;
               w_state_nxt = TX_DATA;
            end
         end
         TX_DATA: begin
            w_msg_ready = w_send_ok;
            if (host.msg_valid && w_send_ok) begin
               if (host.msg_data != CMD_TERM) begin
                  w_issue     = 1'b1;
                  w_issue_dat = host.msg_data;
               end else begin
                  w_err_nxt = ERR_FF;
               end
               if (host.msg_last) w_state_nxt = TX_TERM;
            end
         end
         TX_TERM: begin
            if (w_send_ok) begin
               w_issue       = 1'b1;
               w_issue_dat   = CMD_TERM;
               w_tmo_cnt_nxt = '0;
               w_state_nxt   = RX_HEX;
            end
         end
         RX_HEX: begin
            if (w_rx_vld) begin
               w_tmo_cnt_nxt = '0;
               if (w_dec[4]) begin
                  w_digest_nxt  = {r_digest[251:0], w_dec[3:0]};
                  w_nib_cnt_nxt = r_nib_cnt + 1'b1;
                  if (r_nib_cnt == '1) w_state_nxt = DONE;
               end else begin
                  w_err_nxt   = ERR_HEX;
                  w_state_nxt = IDLE;
               end
            end else if (r_tmo_cnt == TMO_LAST) begin
               w_err_nxt   = ERR_TMO;
               w_state_nxt = IDLE;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_err      <= ERR_OK;
         r_digest   <= '0;
         r_nib_cnt  <= '0;
         r_tmo_cnt  <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_tx_pend  <= 1'b0;
         r_tx_seen  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_err      <= w_err_nxt;
         r_digest   <= w_digest_nxt;
         r_nib_cnt  <= w_nib_cnt_nxt;
         r_tmo_cnt  <= w_tmo_cnt_nxt;
         r_tx_start <= w_issue;
         if (w_issue) begin
            r_tx_data <= w_issue_dat;
            r_tx_pend <= 1'b1;
            r_tx_seen <= 1'b0;
         end else if (r_tx_pend) begin
            if (w_tx_busy)      r_tx_seen <= 1'b1;
            else if (r_tx_seen) r_tx_pend <= 1'b0;
         end
      end
   end

   assign host.msg_ready    = w_msg_ready;
   assign host.digest       = r_digest;
   assign host.digest_valid = (r_state == DONE) && (r_err == ERR_OK);
   assign host.busy         = (r_state != IDLE);
   assign host.err          = r_err;
endmodule

// File: tb/tb_sha256_uart_host.sv
// Bench: UART device model decodes the host's line and replies with hex text; a reference model
// predicts line bytes, err, digest and digest_valid from the protocol rules.
module tb_sha256_uart_host;
   localparam int CLK_FREQ = 40;
   localparam int BAUD     = 10;
   localparam int BDIV     = CLK_FREQ / BAUD;
   localparam int TMO      = 200;
   localparam logic [255:0] ABC_DIGEST =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam string ABC_LC = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
   localparam string ABC_UC = "BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD";

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_tx;
   logic uart_rx = 1'b1;
   int   checks = 0;
   int   errors = 0;

   byte unsigned tx_q[$];
   byte unsigned msg_q[$];
   int           dv_cnt = 0;
   logic         chk_idle = 1'b0;
   logic [255:0] exp_digest = '0;
   logic [1:0]   exp_err = 2'd0;

   always #5 clk = ~clk;

   sha256_uart_host_if bus();

   sha256_uart_host #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .host      (bus),
      .o_uart_tx (uart_tx),
      .i_uart_rx (uart_rx)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int hexval(input byte unsigned c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
      return -1;
   endfunction

   function automatic logic [255:0] model_parse(input string s);
      logic [255:0] d = '0;
      for (int i = 0; i < 64; i++) d = (d << 4) | 256'(hexval(s[i]));
      return d;
   endfunction

   // Line monitor: 8N1 receiver sampling mid-bit on uart_tx.
   initial begin : line_mon
      byte unsigned b;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            repeat (BDIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BDIV) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (BDIV) @(negedge clk);
            tx_q.push_back(b);
         end
      end
   end

   // Per-cycle compare against the model while outputs are meaningful.
   always @(negedge clk) begin
      if (bus.digest_valid === 1'b1) begin
         dv_cnt++;
         chk("digest_at_valid", bus.digest, exp_digest);
      end
      if (chk_idle) begin
         chk("idle_busy", bus.busy, 0);
         chk("idle_err", bus.err, exp_err);
         chk("idle_digest", bus.digest, exp_digest);
         chk("idle_ready", bus.msg_ready, 0);
      end
   end

   task automatic send_byte(input byte unsigned b);
      uart_rx = 1'b0;
      repeat (BDIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BDIV) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (BDIV) @(negedge clk);
   endtask

   task automatic feed(input byte unsigned b, input logic last);
      int k = 0;
      bus.msg_data = b; bus.msg_valid = 1'b1; bus.msg_last = last;
      while (bus.msg_ready !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("msg_accept", 256'(k < 1000), 1);
      @(negedge clk);
      bus.msg_valid = 1'b0; bus.msg_last = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
   endtask

   task automatic run_txn(input string name, input string reply, input int nsend);
      byte unsigned exp_line[$];
      logic [1:0]   e_err = 2'd0;
      logic [255:0] d = exp_digest;
      int           nib = 0;
      logic         bad = 1'b0;
      int           k = 0;
      int           dv0;
      exp_line.push_back(8'h01);
      foreach (msg_q[i]) begin
         if (msg_q[i] == 8'hFF) e_err = 2'd1;
         else                   exp_line.push_back(msg_q[i]);
      end
      exp_line.push_back(8'hFF);
      for (int i = 0; i < nsend && !bad; i++) begin
         int v = hexval(reply[i]);
         if (v < 0) bad = 1'b1;
         else begin
            d = (d << 4) | 256'(v);
            nib++;
         end
      end
      if (bad)           e_err = 2'd2;
      else if (nib < 64) e_err = 2'd3;

      chk_idle = 1'b0;
      tx_q.delete();
      dv0 = dv_cnt;
      pulse_start();
      foreach (msg_q[i]) feed(msg_q[i], i == msg_q.size() - 1);
      while (tx_q.size() < exp_line.size() && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_line_len"}, tx_q.size(), exp_line.size());
      foreach (exp_line[i])
         if (i < tx_q.size()) chk($sformatf("%s_line%0d", name, i), tx_q[i], exp_line[i]);

      exp_digest = d;
      exp_err    = e_err;
      for (int i = 0; i < nsend; i++) send_byte(reply[i]);
      k = 0;
      while (bus.busy !== 1'b0 && k < 4 * TMO) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_busy_fall"}, 256'(k < 4 * TMO), 1);
      if (e_err == 2'd3)
         chk({name, "_tmo_window"}, 256'(k >= TMO - 2 * BDIV && k <= TMO + 2 * BDIV), 1);
      chk({name, "_err"}, bus.err, e_err);
      chk({name, "_dv_count"}, dv_cnt - dv0, (e_err == 2'd0) ? 1 : 0);
      chk({name, "_digest"}, bus.digest, d);
      chk_idle = 1'b1;
      repeat (8) @(negedge clk);
      chk_idle = 1'b0;
   endtask

   initial begin : main
      string s;
      logic  hi_ok;
      bus.start = 1'b0; bus.msg_valid = 1'b0; bus.msg_last = 1'b0; bus.msg_data = 8'h00;
      #22;
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_digest", bus.digest, 0);
      chk("rst_dv", bus.digest_valid, 0);
      chk("rst_ready", bus.msg_ready, 0);
      chk("rst_line", uart_tx, 1);
      chk("pin_parse_lc", model_parse(ABC_LC), ABC_DIGEST);
      chk("pin_parse_uc", model_parse(ABC_UC), ABC_DIGEST);
      chk("pin_hex_F", 256'(hexval(8'h46)), 15);
      chk("pin_hex_g", 256'(hexval(8'h67) < 0), 1);
      @(negedge clk) rst = 1'b0;
      chk_idle = 1'b1;
      repeat (5) @(negedge clk);
      chk_idle = 1'b0;

      msg_q.delete(); msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
      run_txn("abc_lc", ABC_LC, 64);
      chk("abc_literal", bus.digest, ABC_DIGEST);
      run_txn("abc_uc", ABC_UC, 64);
      s = ABC_LC;
      s.putc(9, 8'h67);
      run_txn("bad_g", s, 10);
      run_txn("silent", ABC_LC, 10);
      msg_q.delete(); msg_q.push_back(8'h41); msg_q.push_back(8'hFF); msg_q.push_back(8'h42);
      run_txn("ff_drop", ABC_LC, 64);

      for (int t = 0; t < 5; t++) begin
         int len  = $urandom_range(1, 5);
         int mode = $urandom_range(0, 5);
         int n    = 64;
         s = ABC_LC;
         msg_q.delete();
         for (int i = 0; i < len; i++)
            msg_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
         for (int i = 0; i < 64; i++) begin
            int v = $urandom_range(0, 15);
            logic up = 1'($urandom_range(0, 1));
            s.putc(i, (v < 10) ? 8'(48 + v) : (up ? 8'(55 + v) : 8'(87 + v)));
         end
         if (mode == 0) begin
            n = $urandom_range(1, 64);
            s.putc(n - 1, 8'h7A);
         end else if (mode == 1) begin
            n = $urandom_range(1, 63);
         end
         run_txn($sformatf("rnd%0d", t), s, n);
      end

      tx_q.delete();
      pulse_start();
      feed(8'h41, 1'b0);
      feed(8'h42, 1'b0);
      repeat (BDIV * 3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_err", bus.err, 0);
      chk("midrst_digest", bus.digest, 0);
      chk("midrst_dv", bus.digest_valid, 0);
      chk("midrst_ready", bus.msg_ready, 0);
      chk("midrst_line", uart_tx, 1);
      @(negedge clk) rst = 1'b0;
      exp_digest = '0;
      exp_err    = 2'd0;
      hi_ok      = 1'b1;
      chk_idle   = 1'b1;
      repeat (20 * BDIV) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) hi_ok = 1'b0;
      end
      chk_idle = 1'b0;
      chk("midrst_line_quiet", hi_ok, 1);
      msg_q.delete(); msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
      run_txn("post_rst", ABC_LC, 64);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sha256_uart_host.md
SHA256_UART_HOST -- requirements
Module: sha256_uart_host

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; BAUD_DIV = CLK_FREQ / BAUD.
REQ-003 Parameter TIMEOUT_CYCLES, default 20_000_000, maximum clk cycles allowed between response bytes.
REQ-004 clk  in  1  single system clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a hash transaction; honoured only in IDLE.
REQ-007 msg_data  in  8  message byte.
REQ-008 msg_valid  in  1  msg_data is valid.
REQ-009 msg_last  in  1  qualifies msg_data as the final byte of the message.
REQ-010 msg_ready  out  1  block accepts msg_data this cycle.
REQ-011 uart_tx  out  1  serial line to the SHA-256 device, 8N1, idle high.
REQ-012 uart_rx  in  1  serial line from the SHA-256 device, 8N1.
REQ-013 digest  out  256  decoded hash; the first received character maps to digest[255:252].
REQ-014 digest_valid  out  1  one-cycle pulse when digest is complete and error-free.
REQ-015 busy  out  1  high whenever the FSM is outside IDLE.
REQ-016 err  out  2  status code: 0 = ok, 1 = 0xFF data byte dropped, 2 = bad hex character, 3 = timeout; holds until the next start.

Function
REQ-017 States SHALL be IDLE, TX_CMD, TX_DATA, TX_TERM, RX_HEX and DONE.
REQ-018 IDLE + start SHALL clear err, clear the nibble counter, and go to TX_CMD; start outside IDLE SHALL be ignored.
REQ-019 TX_CMD SHALL send byte 0x01, then go to TX_DATA.
REQ-020 TX_DATA SHALL drive msg_ready high only when the transmitter is idle and no send is pending; a byte is accepted on msg_valid && msg_ready.
REQ-021 An accepted byte other than 0xFF SHALL be transmitted; an accepted 0xFF SHALL be dropped (not transmitted) and SHALL set err=1, and the transaction continues.
REQ-022 An accepted byte with msg_last SHALL cause transition to TX_TERM after that byte's send is issued (or after it is dropped).
REQ-023 TX_TERM SHALL send 0xFF, then go to RX_HEX.
REQ-024 Send rule: pulse tx_start to uart_tx_core for exactly 1 cycle; issue no further tx_start until tx_busy has been seen high and then low.
REQ-025 RX_HEX SHALL decode each received byte: '0'-'9' gives 0-9, 'a'-'f' and 'A'-'F' give 10-15; the nibble SHALL be shifted into digest from the MSB side (digest <= {digest[251:0], nib}).
REQ-026 RX_HEX, any other character: set err=2 and go to IDLE with no digest_valid.
REQ-027 RX_HEX timeout counter: reset on entry to RX_HEX and on every received byte; on reaching TIMEOUT_CYCLES, set err=3 and go to IDLE.
REQ-028 After the 64th valid nibble the FSM SHALL go to DONE; DONE pulses digest_valid for 1 cycle if err==0 (err=1 suppresses it), then returns to IDLE.
REQ-029 Received bytes outside RX_HEX SHALL be ignored.
REQ-030 digest SHALL hold its value in IDLE until the next start.
REQ-031 A 6-bit nibble counter SHALL be used; its wrap 63->0 SHALL coincide with entry to DONE.

Reset
REQ-032 rst SHALL asynchronously force: IDLE, msg_ready=0, digest=0, digest_valid=0, busy=0, err=0, tx_start=0, all counters 0; uart_tx SHALL be idle high.
REQ-033 rst mid-transaction SHALL abandon the transaction with no further bytes sent; the first start after reset begins cleanly with 0x01.

Structure
REQ-034 A shared package SHALL hold the command constants (CMD_START=0x01, CMD_TERM=0xFF), the err code constants, the state encoding, and the ASCII-to-nibble decode function.
REQ-035 The block SHALL instantiate the existing uart_tx_core and uart_rx_core with BAUD_DIV; no new sub-module.

Verification
REQ-036 start, then "abc" with msg_last on 'c' -> uart_tx sends 01 61 62 63 FF; device model replies "ba7816bf...f20015ad" -> digest=0xba7816bf...f20015ad, a single digest_valid pulse, err=0.
REQ-037 Same transaction, reply in uppercase hex -> identical digest, err=0.
REQ-038 Reply containing 'g' as the 10th character -> err=2, no digest_valid, busy falls.
REQ-039 Device model sends 10 characters, then goes silent -> err=3 after TIMEOUT_CYCLES (use a reduced value in the bench), back to IDLE.
REQ-040 Message 41 FF 42 -> line carries 01 41 42 FF, err=1, no digest_valid.
REQ-041 rst asserted during the second data byte -> outputs reach reset values immediately, uart_tx goes idle high, and the next start sends 0x01 first.
